// File: rtl/pipeline_control.sv
// Stall/flush/forward sequencer for the 5-stage LC-3b pipeline.
// Optional performance counters are built only when PIPE_PERF_EN is defined.

package lc3b_types;
  typedef logic [2:0] lc3b_reg;
endpackage

module pipeline_control
  import lc3b_types::*;
(
  input  logic        clk,
  input  logic        reset,
  input  lc3b_reg     de_ex_rs,
  input  lc3b_reg     de_ex_rt,
  input  logic        de_ex_uses_rs,
  input  logic        de_ex_uses_rt,
  input  lc3b_reg     ex_mem_dr,
  input  lc3b_reg     mem_wb_dr,
  input  logic        ex_mem_regwrite,
  input  logic        mem_wb_regwrite,
  input  logic        ex_mem_is_load,
  input  logic        ex_mem_is_store,
  input  lc3b_reg     ex_mem_st_src,
  input  logic        dmem_req,
  input  logic        dmem_resp,
  input  logic        imem_resp,
  input  logic        br_taken,
  output logic        load_pc,
  output logic        load_if_de,
  output logic        load_de_ex,
  output logic        load_ex_mem,
  output logic        load_mem_wb,
  output logic        flush_if_de,
  output logic        flush_de_ex,
  output logic        bubble_ex_mem,
  output logic        pc_redirect,
  output logic [1:0]  fwd_a_sel,
  output logic [1:0]  fwd_b_sel,
  output logic        fwd_st_sel,
  output logic [15:0] stall_cycles,
  output logic [15:0] flush_events
);

  typedef enum logic {RUN, LU_STALL} state_t;

  state_t state, state_next;
  logic   br_pend, br_pend_next;
  logic   br_accept;

  logic mem_hit_rs, mem_hit_rt, wb_hit_rs, wb_hit_rt;
  logic dmem_wait, load_use;

  assign mem_hit_rs = ex_mem_regwrite & de_ex_uses_rs & (ex_mem_dr == de_ex_rs);
  assign mem_hit_rt = ex_mem_regwrite & de_ex_uses_rt & (ex_mem_dr == de_ex_rt);
  assign wb_hit_rs  = mem_wb_regwrite & de_ex_uses_rs & (mem_wb_dr == de_ex_rs);
  assign wb_hit_rt  = mem_wb_regwrite & de_ex_uses_rt & (mem_wb_dr == de_ex_rt);

  assign dmem_wait = dmem_req & ~dmem_resp;
  assign load_use  = (state == RUN) & ex_mem_is_load & (mem_hit_rs | mem_hit_rt);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= RUN;
      br_pend <= 1'b0;
    end else begin
      state   <= state_next;
      br_pend <= br_pend_next;
    end
  end

  always_comb begin
    load_pc       = 1'b1;
    load_if_de    = 1'b1;
    load_de_ex    = 1'b1;
    load_ex_mem   = 1'b1;
    load_mem_wb   = 1'b1;
    flush_if_de   = 1'b0;
    flush_de_ex   = 1'b0;
    bubble_ex_mem = 1'b0;
    pc_redirect   = 1'b0;
    br_accept     = 1'b0;
    state_next    = state;
    br_pend_next  = br_pend;

    if (reset) begin
      load_pc       = 1'b0;
      load_if_de    = 1'b0;
      load_de_ex    = 1'b0;
      load_ex_mem   = 1'b0;
      load_mem_wb   = 1'b0;
      flush_if_de   = 1'b1;
      flush_de_ex   = 1'b1;
      bubble_ex_mem = 1'b1;
      state_next    = RUN;
      br_pend_next  = 1'b0;
    end else if (dmem_wait) begin
      // Whole pipe freezes; state and pending redirect ride through unchanged.
      load_pc     = 1'b0;
      load_if_de  = 1'b0;
      load_de_ex  = 1'b0;
      load_ex_mem = 1'b0;
      load_mem_wb = 1'b0;
    end else if (br_taken) begin
      flush_if_de   = 1'b1;
      flush_de_ex   = 1'b1;
      bubble_ex_mem = 1'b1;
      br_accept     = 1'b1;
      state_next    = RUN;
      if (imem_resp) begin
        pc_redirect  = 1'b1;
        br_pend_next = 1'b0;
      end else begin
        load_pc      = 1'b0;
        br_pend_next = 1'b1;
      end
    end else if (load_use) begin
      load_pc       = 1'b0;
      load_if_de    = 1'b0;
      load_de_ex    = 1'b0;
      bubble_ex_mem = 1'b1;
      state_next    = LU_STALL;
    end else begin
      state_next = RUN;
      if (!imem_resp) begin
        load_pc     = 1'b0;
        load_if_de  = 1'b0;
        flush_de_ex = 1'b1;
      end else if (br_pend) begin
        pc_redirect  = 1'b1;
        br_pend_next = 1'b0;
      end
      // Anything fetched before the redirect lands is wrong-path.
      if (br_pend && load_if_de) flush_if_de = 1'b1;
    end
  end

  always_comb begin
    fwd_a_sel  = 2'b00;
    fwd_b_sel  = 2'b00;
    fwd_st_sel = 1'b0;
    if (!reset) begin
      if (mem_hit_rs && !ex_mem_is_load) fwd_a_sel = 2'b01;
      else if (wb_hit_rs)                fwd_a_sel = 2'b10;
      if (mem_hit_rt && !ex_mem_is_load) fwd_b_sel = 2'b01;
      else if (wb_hit_rt)                fwd_b_sel = 2'b10;
      fwd_st_sel = ex_mem_is_store & mem_wb_regwrite & (mem_wb_dr == ex_mem_st_src);
    end
  end

`ifdef PIPE_PERF_EN
  logic [15:0] stall_cnt, flush_cnt;

  // Saturating counters; a frozen branch cycle is not counted as accepted.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt <= 16'd0;
      flush_cnt <= 16'd0;
    end else begin
      if (!load_pc && stall_cnt != 16'hFFFF) stall_cnt <= stall_cnt + 16'd1;
      if (br_accept && flush_cnt != 16'hFFFF) flush_cnt <= flush_cnt + 16'd1;
    end
  end

  assign stall_cycles = stall_cnt;
  assign flush_events = flush_cnt;
`else
  assign stall_cycles = 16'd0;
  assign flush_events = 16'd0;
`endif

endmodule

// File: doc/pipeline_control.md
# pipeline_control

Central stall/flush/forward sequencer for the 5-stage LC-3b pipeline (IF, DE, EX, MEM, WB). It takes per-stage register fields, write-enables and memory handshakes, and drives the pipeline-register load enables, bubble/flush controls and EX-stage forwarding mux selects. It owns the load-use stall state machine and the pending-redirect register for taken branches that resolve during an instruction-fetch wait. It sits beside the datapath and is the only block that drives the stage enables.

## Interface
- No parameters. Register fields use `lc3b_reg` (3 bits) from `lc3b_types`.
- `clk` in 1: pipeline clock.
- `reset` in 1: asynchronous, active-high.
- `de_ex_rs`, `de_ex_rt` in 3: source registers of the instruction in EX.
- `de_ex_uses_rs`, `de_ex_uses_rt` in 1: the EX instruction actually reads that source.
- `ex_mem_dr`, `mem_wb_dr` in 3: destinations of the instructions in MEM and WB.
- `ex_mem_regwrite`, `mem_wb_regwrite` in 1: that instruction writes `dr`.
- `ex_mem_is_load` in 1: MEM instruction is LDR/LDB/LDI.
- `ex_mem_is_store` in 1: MEM instruction is STR/STB/STI.
- `ex_mem_st_src` in 3: store-data source register of the MEM instruction.
- `dmem_req` in 1: MEM stage is accessing data memory this cycle.
- `dmem_resp` in 1: data-memory access completes this cycle.
- `imem_resp` in 1: instruction fetch completes this cycle.
- `br_taken` in 1: control transfer resolved taken in MEM.
- `load_pc`, `load_if_de`, `load_de_ex`, `load_ex_mem`, `load_mem_wb` out 1 each: stage register enables.
- `flush_if_de`, `flush_de_ex`, `bubble_ex_mem` out 1 each: load a NOP into that register. These are only meaningful when the matching load is 1.
- `pc_redirect` out 1: PC mux selects the branch target.
- `fwd_a_sel`, `fwd_b_sel` out 2: EX operand select. 00 = regfile, 01 = EX/MEM ALU result, 10 = MEM/WB writeback value.
- `fwd_st_sel` out 1: store-data select. 1 = MEM/WB writeback value.
- `stall_cycles`, `flush_events` out 16 each: performance counters.

## Operation
- States: RUN, LU_STALL.
- Match qualifiers: `mem_hit_x = ex_mem_regwrite & de_ex_uses_x & (ex_mem_dr == de_ex_rx)`. `wb_hit_x` is defined the same way using `mem_wb_*`.
- Forwarding priority is MEM over WB. If `mem_hit_x` and not a load, `fwd_x_sel` = 01. Else if `wb_hit_x`, `fwd_x_sel` = 10. Else 00.
- `fwd_st_sel` = `ex_mem_is_store & mem_wb_regwrite & (mem_wb_dr == ex_mem_st_src)`.
- Load-use: `ex_mem_is_load & (mem_hit_rs | mem_hit_rt)` while in RUN.
  - Response: hold PC, IF/DE and DE/EX; assert `bubble_ex_mem`; go to LU_STALL.
- LU_STALL:
  - Lasts one cycle; the load has moved to WB and is forwarded via 10.
  - Load-use detection is suppressed.
  - Returns to RUN.
- Priority, highest first:
  1. D-memory wait (`dmem_req & ~dmem_resp`): all five loads = 0. FSM state and `br_pend` hold.
  2. Taken branch: `flush_if_de`, `flush_de_ex`, `bubble_ex_mem` = 1, `load_mem_wb` = 1, FSM forced to RUN.
     - If `imem_resp` = 1: `load_pc` = 1, `pc_redirect` = 1.
     - If `imem_resp` = 0: set `br_pend`.
  3. Load-use stall.
  4. I-fetch wait (`~imem_resp`): `load_pc` = `load_if_de` = 0, `flush_de_ex` = 1. Downstream stages advance.
- `br_pend`:
  - While set, `flush_if_de` = 1 on every cycle IF/DE loads.
  - On the first cycle with `imem_resp` and no D-memory wait: `load_pc` = 1, `pc_redirect` = 1, then clear.
  - The branch target register is held by the datapath.
- A branch flush outranks a same-cycle load-use. The load-use consumer is flushed, so no stall occurs.

## Timing
- The state and `br_pend` registers are the only sequential logic besides the counters. All control outputs are combinational from state, `br_pend` and inputs, so there is zero added latency.
- Load-use costs exactly 1 bubble. A taken branch costs 3 flushed slots plus the remaining I-fetch wait.
- Reset asserted, asynchronously:
  - state = RUN, `br_pend` = 0, counters = 0.
  - All load enables = 0; `flush_if_de` = `flush_de_ex` = `bubble_ex_mem` = 1.
  - `pc_redirect` = 0, forward selects = 0.
- Reset mid-stall abandons the stall. The first cycle after release is RUN with no pending redirect.
- A D-memory wait that overlaps LU_STALL extends LU_STALL until `dmem_resp`.

## Configuration
- `PIPE_PERF_EN` defined:
  - `stall_cycles` increments on every cycle with `load_pc` = 0 and reset low.
  - `flush_events` increments once per taken branch accepted (priority 2 active, not frozen).
  - Both counters saturate at 16'hFFFF.
- Undefined: both outputs are constant 0 and no counter flops are built.

## Test plan
- R1 = ADD, then ADD R2, R1, R1 immediately after → both `fwd_a_sel` and `fwd_b_sel` = 01, no stall. One slot later → 10.
- LDR R3, then ADD R4, R3, R0 → one cycle with `load_de_ex` = 0 and `bubble_ex_mem` = 1, then `fwd_a_sel` = 10. `stall_cycles` = 1.
- LDR R5, then STR R5 → `fwd_st_sel` = 1 when the STR is in MEM, no stall.
- `dmem_req` = 1, `dmem_resp` low for 4 cycles → all loads 0 for 4 cycles, then all 1. `stall_cycles` = 4.
- `br_taken` with `imem_resp` = 0 for 2 cycles → 3 flushes, `br_pend` = 1, `pc_redirect` pulses once on the `imem_resp` cycle. `flush_events` = 1.
- `reset` pulsed during LU_STALL → outputs take reset values immediately. After release, no bubble and counters = 0.
